// File: rtl/sample_decimator_pkg.sv
// sample_decimator_pkg
//   Shared constants and helpers for the sample decimator slice.
//   DEF_DATA_W / DEF_FIFO_DEPTH : default AD word width and FIFO depth.
//   ACC_EXTRA_W / ACC_W         : averaging accumulator headroom and width.
//   lvl_width()                 : width of a 0..depth occupancy count.
package sample_decimator_pkg;
   localparam int DEF_DATA_W     = 12;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int ACC_EXTRA_W    = 7;
   localparam int ACC_W          = DEF_DATA_W + ACC_EXTRA_W;

   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/sample_decimator_if.sv
// sample_decimator_if
//   Valid/ready output stream from the decimator to the demodulator.
//   out_data  : FIFO head word
//   out_valid : head word present
//   out_ready : consumer takes out_data this cycle
//   master = producer (decimator), slave = consumer.
interface sample_decimator_if
   import sample_decimator_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sample_decimator_fifo.sv
// sync_fifo_fwft
//   Reusable single-clock first-word-fall-through FIFO, async active-low reset.
//   i_clk, i_rst_n : clock / reset
//   i_push, i_wdata: write request and data (ignored when full unless popping)
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head word, valid whenever o_empty is low
//   o_full, o_empty, o_level : registered occupancy status
module sync_fifo_fwft
   import sample_decimator_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = DEF_DATA_W,
   parameter int LVL_W = lvl_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~o_empty;
   // When full, a same-cycle pop frees the head slot that wr_ptr points at.
   assign w_push = i_push & (~o_full | w_pop);

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end
endmodule

// File: rtl/sample_decimator.sv
// sample_decimator
//   Turns rising edges of the rate-generator sample clock into capture strobes,
//   captures one AD word per strobe into an output FWFT FIFO.
//   clk_in, RST_n : sole clock, async active-low reset
//   en            : capture enable (FIFO keeps draining while low)
//   clk_sample    : sample clock, synchronous to clk_in
//   ad_data       : AD word, valid every cycle
//   out_if        : valid/ready output stream (master)
//   fifo_level    : stored entries 0..FIFO_DEPTH
//   overflow      : sticky, a capture was dropped; cleared by clr_ovf
//   Optional macro SAMPLE_DECIMATOR_AVG_EN adds avg_shift / short_win and
//   boxcar averaging of 2^avg_shift samples between strobes.
module sample_decimator
   import sample_decimator_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LVL_W      = lvl_width(FIFO_DEPTH)
) (
   input  logic                 clk_in,
   input  logic                 RST_n,
   input  logic                 en,
   input  logic                 clk_sample,
   input  logic [DATA_W-1:0]    ad_data,
   sample_decimator_if.master   out_if,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 overflow,
   input  logic                 clr_ovf
`ifdef SAMPLE_DECIMATOR_AVG_EN
   ,
   input  logic [2:0]           avg_shift,
   output logic                 short_win
`endif
);
   logic              r_clk_sample_d;
   logic              r_overflow;
   logic              w_strobe;
   logic              w_full;
   logic              w_empty;
   logic              w_drop;
   logic [DATA_W-1:0] w_push_data;

   // Reset high so a clk_sample already high at reset release is not an edge.
   always_ff @(posedge clk_in or negedge RST_n) begin
      if (!RST_n) r_clk_sample_d <= 1'b1;
      else        r_clk_sample_d <= clk_sample;
   end

   assign w_strobe = clk_sample & ~r_clk_sample_d & en;
   // Full implies non-empty, so out_ready alone decides whether a pop frees space.
   assign w_drop   = w_strobe & w_full & ~out_if.out_ready;

   always_ff @(posedge clk_in or negedge RST_n) begin
      if (!RST_n)       r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
   end

   assign overflow = r_overflow;

`ifdef SAMPLE_DECIMATOR_AVG_EN
   localparam int AW = DATA_W + ACC_EXTRA_W;

   logic [AW-1:0] r_acc;
   logic [7:0]    r_cnt;
   logic          r_short_win;
   logic [7:0]    w_win;
   logic          w_win_full;

   assign w_win      = 8'd1 << avg_shift;
   assign w_win_full = (r_cnt >= w_win);

   // Window restarts at each strobe and holds once 2^avg_shift samples are in.
   always_ff @(posedge clk_in or negedge RST_n) begin
      if (!RST_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (!en || w_strobe) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_cnt < w_win) begin
         r_acc <= r_acc + AW'(ad_data);
         r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk_in or negedge RST_n) begin
      if (!RST_n)                      r_short_win <= 1'b0;
      else if (w_strobe & ~w_win_full) r_short_win <= 1'b1;
      else if (clr_ovf)                r_short_win <= 1'b0;
   end

   assign short_win   = r_short_win;
   assign w_push_data = w_win_full ? DATA_W'(r_acc >> avg_shift) : ad_data;
`else
   assign w_push_data = ad_data;
`endif

   sync_fifo_fwft #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W),
      .LVL_W (LVL_W)
   ) u_fifo (
      .i_clk   (clk_in),
      .i_rst_n (RST_n),
      .i_push  (w_strobe),
      .i_wdata (w_push_data),
      .i_pop   (out_if.out_ready),
      .o_rdata (out_if.out_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign out_if.out_valid = ~w_empty;
endmodule
